// File: rtl/c1_frame_sequencer.sv
// c1_frame_sequencer: streams one image frame from the image buffer into the C1
// engine and collects its per-position results into the result buffer.
//
// state  | meaning
// IDLE   | waiting for cmd_start
// START  | one-cycle c1_start pulse, frame counters and cmd_err cleared
// WAIT_W | waiting for C1 weights, bounded by the timeout timer
// FEED   | streaming IMG_PIX pixels to C1 in address order
// DRAIN  | collecting the remaining results, bounded by the timeout timer
// DONE   | one-cycle cmd_done pulse
// ERR    | cmd_err raised, back to IDLE
module c1_frame_sequencer #(
    parameter int IMG_PIX     = 1024,
    parameter int OUT_PIX     = 784,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_start,
    output logic              cmd_busy,
    output logic              cmd_done,
    output logic              cmd_err,
    output logic              img_rd_en,
    output logic [9:0]        img_rd_addr,
    input  logic [7:0]        img_rd_data,
    output logic              c1_start,
    input  logic              c1_weights_loaded,
    output logic              c1_pixel_valid,
    output logic signed [7:0] c1_pixel,
    input  logic              c1_pixel_ready,
    input  logic              c1_out_valid,
    input  logic [47:0]       c1_out_data,
    output logic              res_wr_en,
    output logic [9:0]        res_wr_addr,
    output logic [47:0]       res_wr_data
);

    localparam int PW = $clog2(IMG_PIX + 1);
    localparam int OW = $clog2(OUT_PIX + 1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [PW-1:0] IMG_PIX_W  = PW'(IMG_PIX);
    localparam logic [PW-1:0] IMG_LAST_W = PW'(IMG_PIX - 1);
    localparam logic [OW-1:0] OUT_PIX_W  = OW'(OUT_PIX);
    localparam logic [TW-1:0] TMR_INIT   = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_W,
        S_FEED,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    logic [PW-1:0] rd_addr;
    logic [PW-1:0] pix_cnt;
    logic [OW-1:0] out_cnt;
    logic [TW-1:0] tmr;
    logic [7:0]    pix_q;
    logic          pix_full;
    logic          rd_inflight;
    logic          xfer;
    logic          res_accept;

    // The returning read data is offered directly; the register only captures it
    // on a stall, so one slot sustains a pixel per cycle with single-cycle read latency.
    assign c1_pixel_valid = pix_full | rd_inflight;
    assign c1_pixel       = pix_full ? pix_q : (rd_inflight ? img_rd_data : 8'd0);
    assign xfer           = c1_pixel_valid & c1_pixel_ready;
    assign img_rd_en      = (state == S_FEED) && (rd_addr < IMG_PIX_W)
                            && (!c1_pixel_valid || xfer);
    assign img_rd_addr    = 10'(rd_addr);
    assign res_accept     = c1_out_valid
                            && ((state == S_WAIT_W) || (state == S_FEED) || (state == S_DRAIN));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rd_addr     <= '0;
            pix_cnt     <= '0;
            out_cnt     <= '0;
            tmr         <= '0;
            pix_q       <= '0;
            pix_full    <= 1'b0;
            rd_inflight <= 1'b0;
            cmd_busy    <= 1'b0;
            cmd_done    <= 1'b0;
            cmd_err     <= 1'b0;
            c1_start    <= 1'b0;
            res_wr_en   <= 1'b0;
            res_wr_addr <= '0;
            res_wr_data <= '0;
        end else begin
            cmd_done  <= 1'b0;
            c1_start  <= 1'b0;
            res_wr_en <= 1'b0;

            if (img_rd_en) begin
                rd_addr <= rd_addr + PW'(1);
            end
            rd_inflight <= img_rd_en;
            if (rd_inflight) begin
                pix_full <= !xfer;
                pix_q    <= img_rd_data;
            end else if (xfer) begin
                pix_full <= 1'b0;
            end
            if (xfer) begin
                pix_cnt <= pix_cnt + PW'(1);
            end

            if (res_accept) begin
                if (out_cnt == OUT_PIX_W) begin
                    cmd_err <= 1'b1;
                end else begin
                    res_wr_en   <= 1'b1;
                    res_wr_addr <= 10'(out_cnt);
                    res_wr_data <= c1_out_data;
                    out_cnt     <= out_cnt + OW'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        state    <= S_START;
                        cmd_busy <= 1'b1;
                        c1_start <= 1'b1;
                    end
                end
                S_START: begin
                    rd_addr     <= '0;
                    pix_cnt     <= '0;
                    out_cnt     <= '0;
                    pix_full    <= 1'b0;
                    rd_inflight <= 1'b0;
                    cmd_err     <= 1'b0;
                    tmr         <= TMR_INIT;
                    state       <= S_WAIT_W;
                end
                S_WAIT_W: begin
                    if (c1_weights_loaded) begin
                        state <= S_FEED;
                    end else if (tmr == '0) begin
                        state   <= S_ERR;
                        cmd_err <= 1'b1;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                S_FEED: begin
                    if (xfer && (pix_cnt == IMG_LAST_W)) begin
                        state <= S_DRAIN;
                        tmr   <= TMR_INIT;
                    end
                end
                S_DRAIN: begin
                    if (out_cnt == OUT_PIX_W) begin
                        state    <= S_DONE;
                        cmd_done <= 1'b1;
                    end else if (c1_out_valid) begin
                        tmr <= TMR_INIT;
                    end else if (tmr == '0) begin
                        state   <= S_ERR;
                        cmd_err <= 1'b1;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    cmd_busy <= 1'b0;
                end
                S_ERR: begin
                    cmd_err  <= 1'b1;
                    state    <= S_IDLE;
                    cmd_busy <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    cmd_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c1_frame_sequencer.sv
// Scoreboard bench for c1_frame_sequencer: image memory, C1 engine stand-in and
// expected pixel/result queues are modelled here; a negedge monitor compares.
module tb_c1_frame_sequencer;

    localparam int IMG_PIX     = 1024;
    localparam int OUT_PIX     = 784;
    localparam int TIMEOUT_CYC = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_start;
    logic        cmd_busy, cmd_done, cmd_err;
    logic        img_rd_en;
    logic [9:0]  img_rd_addr;
    logic [7:0]  img_rd_data;
    logic        c1_start;
    logic        c1_weights_loaded;
    logic        c1_pixel_valid;
    logic [7:0]  c1_pixel;
    logic        c1_pixel_ready;
    logic        c1_out_valid;
    logic [47:0] c1_out_data;
    logic        res_wr_en;
    logic [9:0]  res_wr_addr;
    logic [47:0] res_wr_data;

    always #5 clk = ~clk;

    c1_frame_sequencer #(
        .IMG_PIX(IMG_PIX), .OUT_PIX(OUT_PIX), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_start(cmd_start), .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data),
        .c1_start(c1_start), .c1_weights_loaded(c1_weights_loaded),
        .c1_pixel_valid(c1_pixel_valid), .c1_pixel(c1_pixel), .c1_pixel_ready(c1_pixel_ready),
        .c1_out_valid(c1_out_valid), .c1_out_data(c1_out_data),
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mem [IMG_PIX];
    logic [7:0]  pix_q [$];
    logic [57:0] wr_q [$];

    int cfg_rdy_pct = 100, cfg_out_pct = 100, cfg_n_out = 0, cfg_w_delay = -1;
    int n_xfer = 0, n_reads = 0, n_wr = 0, n_done = 0, n_cstart = 0, n_busy_post = 0;
    int emitted = 0, w_cnt = -1;
    longint cyc = 0, first_xfer = 0, last_xfer = 0;
    logic       rd_req = 1'b0;
    logic [9:0] rd_addr_q = '0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_pix = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: mid-cycle sampling; a transfer/read/write seen here happens at the next edge.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_stall = 1'b0;
            rd_req     = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {c1_pixel_valid, c1_pixel}, {1'b1, prev_pix});
            prev_stall = c1_pixel_valid && !c1_pixel_ready;
            prev_pix   = c1_pixel;
            if (c1_pixel_valid && c1_pixel_ready) begin
                if (pix_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pixel: got transfer 0x%0h, expected none", c1_pixel);
                end else begin
                    chk("pixel", c1_pixel, pix_q.pop_front());
                end
                if (n_xfer == 0) first_xfer = cyc;
                last_xfer = cyc;
                n_xfer++;
            end
            rd_req    = img_rd_en;
            rd_addr_q = img_rd_addr;
            if (img_rd_en) begin
                chk("rd_addr", img_rd_addr, n_reads);
                n_reads++;
            end
            if (res_wr_en) begin
                if (wr_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL res_wr: got write addr %0d, expected none", res_wr_addr);
                end else begin
                    chk("res_wr", {res_wr_addr, res_wr_data}, wr_q.pop_front());
                end
                n_wr++;
            end
            if (c1_start) begin
                n_cstart++;
                w_cnt = 0;
            end
            if (cmd_done) n_done++;
            if (cmd_busy && !c1_start && n_cstart > 0) n_busy_post++;
        end
    end

    // Environment: synchronous image RAM, C1 weights loader and C1 result source.
    always @(posedge clk) begin
        int owed;
        logic [63:0] r;
        #1;
        img_rd_data    = rd_req ? mem[rd_addr_q] : 8'($urandom);
        c1_pixel_ready = ($urandom_range(99) < cfg_rdy_pct);
        if (w_cnt >= 0) w_cnt++;
        c1_weights_loaded = (cfg_w_delay >= 0) && (w_cnt >= cfg_w_delay);
        if (n_xfer >= IMG_PIX)                  owed = cfg_n_out;
        else if (n_xfer > IMG_PIX - OUT_PIX)    owed = n_xfer - (IMG_PIX - OUT_PIX);
        else                                    owed = 0;
        if (owed > cfg_n_out) owed = cfg_n_out;
        if (emitted < owed && $urandom_range(99) < cfg_out_pct) begin
            r = {$urandom, $urandom};
            c1_out_valid = 1'b1;
            c1_out_data  = r[47:0];
            if (emitted < OUT_PIX) wr_q.push_back({10'(emitted), r[47:0]});
            emitted++;
        end else begin
            c1_out_valid = 1'b0;
            c1_out_data  = 48'($urandom);
        end
    end

    task automatic setup_frame(input int w_delay, input int rdy_pct, input int out_pct,
                               input int n_out, input bit ramp, input bit expect_pix);
        cfg_w_delay = w_delay;
        cfg_rdy_pct = rdy_pct;
        cfg_out_pct = out_pct;
        cfg_n_out   = n_out;
        w_cnt       = -1;
        for (int i = 0; i < IMG_PIX; i++) mem[i] = ramp ? 8'(i) : 8'($urandom);
        pix_q.delete();
        wr_q.delete();
        n_xfer = 0; n_reads = 0; n_wr = 0; n_done = 0;
        n_cstart = 0; n_busy_post = 0; emitted = 0;
        if (expect_pix) for (int i = 0; i < IMG_PIX; i++) pix_q.push_back(mem[i]);
        @(negedge clk); #1;
        cmd_start = 1'b1;
        @(negedge clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic end_frame(input string tag, input int exp_xfer, input int exp_wr,
                             input int exp_done, input bit exp_err,
                             input bit chk_contig, input bit chk_tmo);
        for (int k = 0; k < 20000 && cmd_busy; k++) begin
            @(negedge clk); #1;
        end
        chk({tag, "_idle"}, cmd_busy, 1'b0);
        chk({tag, "_xfers"}, n_xfer, exp_xfer);
        chk({tag, "_pix_left"}, pix_q.size(), 0);
        chk({tag, "_writes"}, n_wr, exp_wr);
        chk({tag, "_done_pulses"}, n_done, exp_done);
        chk({tag, "_cmd_err"}, cmd_err, exp_err);
        chk({tag, "_c1_start_cycles"}, n_cstart, 1);
        if (chk_contig) chk({tag, "_xfer_span"}, last_xfer - first_xfer + 1, IMG_PIX);
        if (chk_tmo) chk({tag, "_busy_after_start"}, n_busy_post, TIMEOUT_CYC + 1);
    endtask

    initial begin
        reset = 1'b1; cmd_start = 1'b0; c1_pixel_ready = 1'b0; c1_weights_loaded = 1'b0;
        c1_out_valid = 1'b0; c1_out_data = '0; img_rd_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {cmd_busy, cmd_done, cmd_err, img_rd_en, img_rd_addr, c1_start,
                          c1_pixel_valid, c1_pixel, res_wr_en, res_wr_addr}, '0);
        chk("reset_wr_data", res_wr_data, '0);
        #1 reset = 1'b0;
        @(negedge clk); #1;

        // nominal: weights after 20 cycles, ready held high, 784 results
        setup_frame(20, 100, 100, OUT_PIX, 1'b0, 1'b1);
        end_frame("nominal", IMG_PIX, OUT_PIX, 1, 1'b0, 1'b1, 1'b0);

        // backpressure with ramp image
        setup_frame(int'($urandom_range(40, 1)), 50, 50, OUT_PIX, 1'b1, 1'b1);
        end_frame("backpressure", IMG_PIX, OUT_PIX, 1, 1'b0, 1'b0, 1'b0);

        // weights never arrive
        setup_frame(-1, 100, 100, OUT_PIX, 1'b0, 1'b0);
        end_frame("weights_timeout", 0, 0, 0, 1'b1, 1'b0, 1'b1);

        // one result too many
        setup_frame(5, 100, 100, OUT_PIX + 1, 1'b0, 1'b1);
        end_frame("overflow", IMG_PIX, OUT_PIX, 1, 1'b1, 1'b1, 1'b0);

        // one result missing
        setup_frame(5, 80, 60, OUT_PIX - 1, 1'b0, 1'b1);
        end_frame("missing", IMG_PIX, OUT_PIX - 1, 0, 1'b1, 1'b0, 1'b0);

        // reset mid-frame with a read in flight
        setup_frame(3, 100, 50, OUT_PIX, 1'b0, 1'b1);
        for (int k = 0; k < 5000 && n_xfer < 500; k++) begin
            @(negedge clk); #1;
        end
        chk("rst_reached_xfer500", n_xfer >= 500, 1'b1);
        chk("rst_read_in_flight", img_rd_en, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_ctl", {cmd_busy, cmd_done, cmd_err, img_rd_en, img_rd_addr, c1_start,
                            c1_pixel_valid, c1_pixel, res_wr_en, res_wr_addr}, '0);
        chk("rst_mid_wr_data", res_wr_data, '0);
        #1 reset = 1'b0;
        setup_frame(7, 60, 50, OUT_PIX, 1'b0, 1'b1);
        end_frame("after_reset", IMG_PIX, OUT_PIX, 1, 1'b0, 1'b0, 1'b0);

        // cmd_start pulsed again during FEED
        setup_frame(10, 100, 100, OUT_PIX, 1'b0, 1'b1);
        for (int k = 0; k < 5000 && n_xfer < 100; k++) begin
            @(negedge clk); #1;
        end
        cmd_start = 1'b1;
        @(negedge clk); #1;
        cmd_start = 1'b0;
        end_frame("ignored_start", IMG_PIX, OUT_PIX, 1, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
